// File: rtl/mem_responder.sv
// Memory-side responder for the MDR port: wait-state insertion in front of a synchronous word array.
// Optional per-word even parity with fault injection when MEM_PARITY_EN is defined.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              rdReq,
  input  logic              wrReq,
`ifdef MEM_PARITY_EN
  input  logic              parityFlip,
  output logic              parityErr,
`endif
  output tri   [DATA_W-1:0] dataOut,
  output logic              ready,
  output logic              busy
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wr;
  logic [DATA_W-1:0] r_dout;
  logic              r_drive;
  logic              r_ready;
  logic              r_busy;
  logic [MEM_W-1:0]  r_mem [2**ADDR_W];

  logic              w_req;
  logic              w_do_write;
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;

  assign w_req      = rdReq | wrReq;
  assign w_do_write = (r_state == S_ACCESS) && r_wr;
  assign w_rd_word  = r_mem[r_addr];

`ifdef MEM_PARITY_EN
  logic r_flip;
  logic r_perr;
  assign w_wr_word = {(^r_data) ^ r_flip, r_data};
  assign parityErr = r_perr;
`else
  assign w_wr_word = r_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      // <= guards against a stuck WAIT should the counter ever read 0
      S_WAIT:   if (r_cnt <= 4'd1) w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_dout  <= '0;
      r_drive <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
`ifdef MEM_PARITY_EN
      r_flip  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_addr <= addr;
          r_data <= dataIn;
          r_wr   <= wrReq;
          r_busy <= 1'b1;
          r_cnt  <= 4'(WAIT_CYCLES);
`ifdef MEM_PARITY_EN
          r_flip <= parityFlip;
`endif
        end
        S_WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        S_ACCESS: begin
          r_ready <= 1'b1;
          if (!r_wr) begin
            r_dout  <= w_rd_word[DATA_W-1:0];
            r_drive <= 1'b1;
`ifdef MEM_PARITY_EN
            r_perr  <= (^w_rd_word[DATA_W-1:0]) != w_rd_word[DATA_W];
`endif
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_drive <= 1'b0;
          r_busy  <= 1'b0;
`ifdef MEM_PARITY_EN
          r_perr  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately outside the reset domain; contents survive reset
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_addr] <= w_wr_word;
  end

  assign dataOut = r_drive ? r_dout : {DATA_W{1'bz}};
  assign ready   = r_ready;
  assign busy    = r_busy;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the MDR memory port. It accepts single-word read and write requests from the MDR/MAR side, inserts a programmable number of wait states, and then performs the access on an internal synchronous word array. Read data is returned on a tri-stated data bus with a one-cycle `ready` strobe. It sits between the MDR memory port and the memory array, and replaces the ideal zero-latency memory model.

## Interface
- `ADDR_W`, default 8: address width; the array holds 2^ADDR_W words.
- `DATA_W`, default 16: word width; matches the MDR data path.
- `WAIT_CYCLES`, default 2: wait states between accept and access; legal range 0–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addr` in ADDR_W: word address, sampled on accept.
- `dataIn` in DATA_W: write data from the MDR memory output, sampled on accept.
- `rdReq` in 1: read request, level-sensitive, sampled only in IDLE.
- `wrReq` in 1: write request, level-sensitive, sampled only in IDLE.
- `dataOut` out DATA_W: read data; all-z except during the ready cycle of a read.
- `ready` out 1: one-cycle completion strobe for reads and writes.
- `busy` out 1: high from accept until return to IDLE.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - WAIT: counts wait states.
  - ACCESS: performs the array access.
  - DONE: presents the result.
- IDLE:
  - If `wrReq` or `rdReq` is high, latch `addr`, `dataIn` and the op, and set `busy`<=1.
  - Go to WAIT if `WAIT_CYCLES`>0, otherwise go to ACCESS.
  - Write has priority when both requests are high. The read is dropped, not queued.
- WAIT:
  - A 4-bit counter loads `WAIT_CYCLES` on accept and decrements each cycle.
  - Go to ACCESS when the counter reaches 1, i.e. after exactly `WAIT_CYCLES` cycles in WAIT.
- ACCESS:
  - Write: `mem[addr_l]`<=`data_l`. Read: `dataOut`<=`mem[addr_l]`.
  - `ready`<=1, then go to DONE.
- DONE:
  - `ready`<=0, `dataOut`<=z, `busy`<=0, then go to IDLE.
  - A request held high is accepted again on the first IDLE edge.
- Requests, `addr` and `dataIn` are ignored while `busy`=1. Changing them mid-operation has no effect.
- `dataOut` is driven only in the DONE cycle of a read. It stays z for writes.
- Address arithmetic: no wrap or range check is needed; `addr` spans the full array.
- Reset (any time, including mid-operation):
  - State goes to IDLE, the counter to 0, `ready`=0, `busy`=0, `dataOut`=z.
  - An in-flight write is not performed.
  - Array contents are not reset.

## Timing
- Accept on edge E0. `ready` is high for exactly one cycle, after edge E0+`WAIT_CYCLES`+1.
- `busy` is high after E0 and low after E0+`WAIT_CYCLES`+2.
- Earliest next accept is edge E0+`WAIT_CYCLES`+3. Back-to-back throughput is `WAIT_CYCLES`+3 cycles per op.
- Read data is valid in the same cycle as `ready`.
- A read issued after a write to the same address returns the new data; there is no hazard because operations are serialized.

## Configuration
- `MEM_PARITY_EN`: defined
  - Each word stores an extra even-parity bit computed from `data_l` at ACCESS.
  - Adds input `parityFlip` (1 bit), sampled on accept. When high, the stored parity bit is inverted for fault injection.
  - Adds output `parityErr` (1 bit), reset 0. It is high with `ready` on a read whose recomputed parity mismatches the stored bit, otherwise 0. Data is still returned.
- `MEM_PARITY_EN`: not defined
  - No parity storage, no `parityFlip` or `parityErr` ports.

## Test plan
- Reset then idle: `reset`=0 mid-cycle -> `ready`=0, `busy`=0, `dataOut`=z immediately, with no clock edge needed.
- Write then read (`WAIT_CYCLES`=2): write 0xBEEF to addr 0x12 accepted at E0 -> `ready` after E3, `dataOut`=z. Read of 0x12 -> `dataOut`=0xBEEF with `ready` 3 edges after its accept, and z the next cycle.
- Simultaneous `rdReq`=`wrReq`=1, addr 0x05, `dataIn`=0x1234 -> write performed, `dataOut` stays z. A later read of 0x05 returns 0x1234.
- Ignored mid-op: change `addr` and raise `wrReq` while `busy`=1 -> no extra `ready`, array unchanged. Held `rdReq` -> reaccepted at E0+5, giving back-to-back `ready` pulses 5 cycles apart.
- Reset mid-write: assert `reset` in the WAIT state of a write of 0xAAAA to 0x20, whose prior value is 0x0F0F -> a later read of 0x20 returns 0x0F0F. Also `WAIT_CYCLES`=0: `ready` after E1.
- `MEM_PARITY_EN`: write 0x0001 with `parityFlip`=1, then read -> `parityErr`=1 with `ready`, `dataOut`=0x0001. Same sequence with `parityFlip`=0 -> `parityErr`=0.
